// File: rtl/debounce_edge_detect_if.sv
// Signal bundle for the debouncer: raw input toward the block, conditioned
// level and edge pulses back out.
interface debounce_edge_detect_if;
  logic d;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  modport master (output d, input q, rise, fall, busy);
  modport slave  (input d, output q, rise, fall, busy);
endinterface

// File: rtl/debounce_edge_detect.sv
// Two-flop synchroniser followed by a 4-state debounce FSM with a stability
// counter; produces a clean level and one-cycle rise/fall pulses.
module debounce_edge_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 gclk,
  input  logic                 grst,
  debounce_edge_detect_if.slave bus
);

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  // cnt+1 == STABLE_CYCLES is tested as cnt == LAST so the compare stays CNT_W wide
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_r, q_nxt;
  logic             rise_r, rise_nxt;
  logic             fall_r, fall_nxt;

  always_ff @(posedge gclk) begin
    if (grst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= LOW;
      cnt    <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      s1     <= bus.d;
      s2     <= s1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
      rise_r <= rise_nxt;
      fall_r <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q_r;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW, WAIT_HIGH: begin
        if (s2) begin
          if (cnt == LAST) begin
            state_nxt = HIGH;
            q_nxt     = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end else begin
          // any low sample throws away a partial count
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      HIGH, WAIT_LOW: begin
        if (!s2) begin
          if (cnt == LAST) begin
            state_nxt = LOW;
            q_nxt     = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end else begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.q    = q_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;
  assign bus.busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: a per-cycle scoreboard for N=4 and N=1
// instances, a vector table for reset/rise/fall, and directed corner sequences.
module tb_debounce_edge_detect;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  initial forever #5 gclk = ~gclk;

  debounce_edge_detect_if if4 ();
  debounce_edge_detect_if if1 ();

  debounce_edge_detect #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
    .gclk(gclk), .grst(grst), .bus(if4.slave));
  debounce_edge_detect #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .gclk(gclk), .grst(grst), .bus(if1.slave));

  typedef struct packed {logic q; logic rise; logic fall; logic busy;} obs_t;
  typedef struct {logic rst; logic d; obs_t exp;} vec_t;

  obs_t sb4[$];
  obs_t sb1[$];
  vec_t vecs[$];

  logic m_s1[2];
  logic m_s2[2];
  logic m_q[2];
  int   m_run[2];

  function automatic obs_t get_obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.q = if4.q; o.rise = if4.rise; o.fall = if4.fall; o.busy = if4.busy;
    end else begin
      o.q = if1.q; o.rise = if1.rise; o.fall = if1.fall; o.busy = if1.busy;
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: q/rise/fall/busy got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: q flips once the synchronised input has disagreed with q for
  // N consecutive samples; busy means a disagreement run is in progress.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      obs_t e;
      logic dk;
      int   n;
      dk = (k == 0) ? if4.d : if1.d;
      n  = (k == 0) ? 4 : 1;
      e  = '0;
      if (grst) begin
        m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_q[k] = 1'b0; m_run[k] = 0;
      end else begin
        if (m_s2[k] != m_q[k]) begin
          m_run[k]++;
          if (m_run[k] == n) begin
            m_q[k]   = ~m_q[k];
            m_run[k] = 0;
            e.rise   = m_q[k];
            e.fall   = ~m_q[k];
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = dk;
      end
      e.q    = m_q[k];
      e.busy = (m_run[k] != 0);
      if (k == 0) sb4.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge gclk);
    model_step();
  end

  initial forever begin
    @(negedge gclk);
    if (sb4.size() > 0) check("sb_n4", get_obs(0), sb4.pop_front());
    if (sb1.size() > 0) check("sb_n1", get_obs(1), sb1.pop_front());
  end

  task automatic add(input logic rst, input logic d, input logic q, input logic r,
                     input logic f, input logic b);
    vec_t v;
    v.rst = rst; v.d = d;
    v.exp.q = q; v.exp.rise = r; v.exp.fall = f; v.exp.busy = b;
    vecs.push_back(v);
  endtask

  task automatic run(input int k, input int n, output int nr, output int nf, output int nb);
    obs_t o;
    nr = 0; nf = 0; nb = 0;
    repeat (n) begin
      @(posedge gclk); #1;
      o = get_obs(k);
      nr += int'(o.rise); nf += int'(o.fall); nb += int'(o.busy);
    end
  endtask

  // Edges until q reaches level, counting the first edge after the call as 1; -1 on timeout.
  task automatic edges_to(input int k, input logic level, output int n);
    obs_t o;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge gclk); #1;
      o = get_obs(k);
      if (o.q === level) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   nr, nf, nb, n, tr, tf, tb;
    obs_t o;
    if4.d = 1'b0;
    if1.d = 1'b0;

    // reset with d=1, then clean rise, then clean fall (N=4)
    add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0); add(0, 1, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0); add(0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      grst  = vecs[i].rst;
      if4.d = vecs[i].d;
      @(posedge gclk); #1;
      check($sformatf("vec%0d", i), get_obs(0), vecs[i].exp);
    end

    // 3-cycle high glitch is rejected, then a full rise with no carry-over
    if4.d = 1'b1; run(0, 3, nr, nf, nb);
    if4.d = 1'b0; run(0, 6, nr, nf, nb);
    check_int("glitch_rise_cnt", nr, 0);
    o = get_obs(0);
    check("glitch_idle", o, obs_t'(4'b0000));
    if4.d = 1'b1; edges_to(0, 1'b1, n);
    check_int("rise_after_glitch_lat", n, 6);
    check_int("rise_pulse", int'(if4.rise), 1);
    run(0, 4, nr, nf, nb);
    check_int("rise_once", nr, 0);

    // 2-cycle low glitch from HIGH gives no fall
    if4.d = 1'b0; run(0, 2, nr, nf, nb);
    if4.d = 1'b1; run(0, 8, nr, nf, nb);
    check_int("low_glitch_fall_cnt", nf, 0);
    check_int("low_glitch_q", int'(if4.q), 1);
    if4.d = 1'b0; edges_to(0, 1'b0, n);
    check_int("fall_lat", n, 6);
    run(0, 4, nr, nf, nb);

    // reset in WAIT_HIGH after cnt reaches 2
    if4.d = 1'b1; run(0, 4, nr, nf, nb);
    check_int("wait_high_busy", int'(if4.busy), 1);
    grst = 1'b1; run(0, 1, nr, nf, nb);
    o = get_obs(0);
    check("reset_mid_wait", o, obs_t'(4'b0000));
    grst = 1'b0; edges_to(0, 1'b1, n);
    check_int("post_reset_lat", n, 6);

    // N=1: 3-edge latency, alternating pulses, never busy
    if1.d = 1'b1; edges_to(1, 1'b1, n);
    check_int("n1_lat", n, 3);
    run(1, 1, nr, nf, nb);
    tr = 0; tf = 0; tb = 0;
    for (int t = 0; t < 8; t++) begin
      if1.d = ~if1.d;
      run(1, 4, nr, nf, nb);
      tr += nr; tf += nf; tb += nb;
    end
    check_int("n1_rises", tr, 4);
    check_int("n1_falls", tf, 4);
    check_int("n1_busy", tb, 0);
    check_int("n1_final_q", int'(if1.q), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
